// File: rtl/lm07_reader.sv
// lm07_reader: SPI-style reader that pulls one 16-bit temperature frame from an LM07 sensor per start.
module lm07_reader #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sio,
  output logic        cs,
  output logic        sck,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] temp_raw,
  output logic [8:0]  temp_int
);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_MAX = 8'(CS_GAP - 1);
  state_t state, state_n;
  logic [7:0] div, div_n;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic [15:0] sr, sr_n, raw_n;
  logic cs_n, sck_n, busy_n, dv_n, div_end;
  assign div_end = div == DIV_MAX;
  assign temp_int = temp_raw[15:7];
  // div doubles as the CS_GAP timer while in GAP
  always_comb begin
    state_n = state;
    div_n = div + 8'd1;
    bit_cnt_n = bit_cnt;
    sr_n = sr;
    raw_n = temp_raw;
    cs_n = cs;
    sck_n = sck;
    busy_n = busy;
    dv_n = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        if (start) begin
          state_n = SETUP;
          cs_n = 1'b0;
          busy_n = 1'b1;
          bit_cnt_n = '0;
        end
      end
      SETUP: if (div_end) begin
        state_n = SHIFT;
        div_n = '0;
        sck_n = 1'b1;
        sr_n = {sr[14:0], sio};
        bit_cnt_n = 5'd1;
      end
      SHIFT: if (div_end) begin
        div_n = '0;
        if (sck) sck_n = 1'b0;
        else if (bit_cnt == 5'd16) begin
          state_n = GAP;
          cs_n = 1'b1;
          dv_n = 1'b1;
          raw_n = sr;
        end else begin
          sck_n = 1'b1;
          sr_n = {sr[14:0], sio};
          bit_cnt_n = bit_cnt + 5'd1;
        end
      end
      GAP: if (div == GAP_MAX) begin
        state_n = IDLE;
        busy_n = 1'b0;
        div_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div <= '0;
      bit_cnt <= '0;
      sr <= '0;
      temp_raw <= '0;
      cs <= 1'b1;
      sck <= 1'b0;
      busy <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state <= state_n;
      div <= div_n;
      bit_cnt <= bit_cnt_n;
      sr <= sr_n;
      temp_raw <= raw_n;
      cs <= cs_n;
      sck <= sck_n;
      busy <= busy_n;
      data_valid <= dv_n;
    end
  end
endmodule

// File: tb/tb_lm07_reader.sv
// tb_lm07_reader: directed checks of lm07_reader against behavioural LM07 sensor models.
module tb_lm07_reader;
  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic sio0, sio1, cs0, cs1, sck0, sck1, busy0, busy1, dv0, dv1;
  logic [15:0] raw0, raw1, word0 = '0, word1 = '0;
  logic [8:0] int0, int1;
  logic [3:0] i0, i1;
  int f0 = 0, b0 = 0, r0 = 0, dvc0 = 0, f1 = 0, b1 = 0, r1 = 0, dvc1 = 0;
  int checks = 0, errors = 0;

  lm07_reader #(.CLK_DIV(4), .CS_GAP(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .sio(sio0), .cs(cs0), .sck(sck0),
    .busy(busy0), .data_valid(dv0), .temp_raw(raw0), .temp_int(int0));
  lm07_reader #(.CLK_DIV(1), .CS_GAP(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sio(sio1), .cs(cs1), .sck(sck1),
    .busy(busy1), .data_valid(dv1), .temp_raw(raw1), .temp_int(int1));

  always #5 clk = ~clk;

  // sensor: bit 15 on cs fall, next bit after every sck fall
  always @(negedge sck0) f0 <= f0 + 1;
  always @(negedge cs0) b0 <= f0;
  always @(posedge sck0) r0 <= r0 + 1;
  always @(posedge clk) if (dv0) dvc0 <= dvc0 + 1;
  assign i0 = 4'(15 - (f0 - b0));
  assign sio0 = word0[i0];
  always @(negedge sck1) f1 <= f1 + 1;
  always @(negedge cs1) b1 <= f1;
  always @(posedge sck1) r1 <= r1 + 1;
  always @(posedge clk) if (dv1) dvc1 <= dvc1 + 1;
  assign i1 = 4'(15 - (f1 - b1));
  assign sio1 = word1[i1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one start pulse on the selected instance; returns cycles with cs low until data_valid
  task automatic frame(input bit u, input logic [15:0] w, output int low);
    int n;
    low = 0;
    n = 0;
    if (u) word1 = w; else word0 = w;
    @(negedge clk);
    if (u) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    while (!(u ? dv1 : dv0) && n < 2000) begin
      if (!(u ? cs1 : cs0)) low++;
      @(negedge clk);
      n++;
    end
    chk("dv_timeout", n < 2000, 1);
  endtask

  initial begin
    int low, rb, db, n, bad;
    repeat (3) @(negedge clk);
    chk("rst_cs", {cs0, cs1}, 2'b11);
    chk("rst_sck", {sck0, sck1}, 2'b00);
    chk("rst_busy", {busy0, busy1}, 2'b00);
    chk("rst_dv", {dv0, dv1}, 2'b00);
    chk("rst_raw", raw0, 16'h0000);
    chk("rst_int", int0, 9'h000);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_cs", cs0, 1);

    rb = r0; db = dvc0;
    frame(0, 16'h0B9F, low);
    chk("a_cs_low", low, 132);
    chk("a_rises", r0 - rb, 16);
    chk("a_raw", raw0, 16'h0B9F);
    chk("a_int", int0, 9'd23);
    chk("a_cs_at_dv", cs0, 1);
    chk("a_sck_at_dv", sck0, 0);
    repeat (7) @(negedge clk);
    chk("a_busy_gap", busy0, 1);
    @(negedge clk);
    chk("a_busy_end", busy0, 0);
    chk("a_dv_count", dvc0 - db, 1);

    frame(0, 16'hF380, low);
    chk("b_raw", raw0, 16'hF380);
    chk("b_int", int0, 9'h1E7);

    rb = r1;
    frame(1, 16'hA5A5, low);
    chk("c_cs_low", low, 33);
    chk("c_rises", r1 - rb, 16);
    chk("c_raw", raw1, 16'hA5A5);
    chk("c_int", int1, 9'h14B);
    repeat (10) @(negedge clk);

    rb = r0; db = dvc0; n = 0;
    word0 = 16'h1234;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (40) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("d_raw_hold", raw0, 16'hF380);
    while (!dv0 && n < 2000) begin @(negedge clk); n++; end
    chk("d_dv_timeout", n < 2000, 1);
    chk("d_raw", raw0, 16'h1234);
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("d_busy_gap", busy0, 1);
    @(negedge clk);
    chk("d_busy_end", busy0, 0);
    repeat (20) @(negedge clk);
    chk("d_no_frame", cs0, 1);
    chk("d_dv_count", dvc0 - db, 1);
    chk("d_rises", r0 - rb, 16);

    rb = r0; db = dvc0; n = 0;
    word0 = 16'h5A5A;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (r0 - rb < 7 && n < 500) begin @(negedge clk); n++; end
    chk("e_rise_timeout", n < 500, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("e_cs", cs0, 1);
    chk("e_sck", sck0, 0);
    chk("e_busy", busy0, 0);
    chk("e_raw", raw0, 16'h0000);
    repeat (40) @(negedge clk);
    chk("e_no_dv", dvc0 - db, 0);
    frame(0, 16'h0C80, low);
    chk("e_cs_low", low, 132);
    chk("e_raw2", raw0, 16'h0C80);
    chk("e_int2", int0, 9'd25);
    repeat (12) @(negedge clk);

    rb = r0; db = dvc0; bad = 0;
    word0 = 16'h0F00;
    start0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!dv0 && n < 2000) begin @(negedge clk); n++; end
      chk("f_dv_timeout", n < 2000, 1);
      chk("f_raw", raw0, 16'h0F00);
      if (k < 2) begin
        n = 0;
        while (cs0 && n < 100) begin
          if (sck0) bad++;
          n++;
          @(negedge clk);
        end
        chk("f_gap", n, 9);
      end
    end
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("f_dv_count", dvc0 - db, 3);
    chk("f_rises", r0 - rb, 48);
    chk("f_sck_cs_high", bad, 0);
    chk("f_int", int0, 9'd30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lm07_reader.md
LM07_READER -- requirements
Module: lm07_reader

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range 1..255.
REQ-002 Parameter CS_GAP, default 8: minimum clk cycles CS stays high after a frame before a new start is accepted; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one 16-bit read frame; sampled only in IDLE.
REQ-006 sio  input  1  serial data from the sensor; MSB first; the sensor shifts on the SCK falling edge.
REQ-007 cs  output  1  sensor chip select, active-low.
REQ-008 sck  output  1  serial clock; idles low.
REQ-009 busy  output  1  high from start acceptance until the CS_GAP interval ends.
REQ-010 data_valid  output  1  one-cycle pulse when temp_raw and temp_int update.
REQ-011 temp_raw  output  16  last complete frame, bit 15 = first bit received.
REQ-012 temp_int  output  9  signed whole degrees C, equal to temp_raw[15:7].

Function
REQ-013 The state machine SHALL have states IDLE, SETUP, SHIFT, GAP.
REQ-014 In IDLE with start=1: next cycle cs=0, busy=1, state=SETUP, divider counter=0.
REQ-015 SETUP SHALL last exactly CLK_DIV cycles with sck=0; it then enters SHIFT and drives sck=1.
REQ-016 In SHIFT, sck SHALL toggle every CLK_DIV cycles, giving 16 high phases and 16 low phases.
REQ-017 On each cycle in which sck is driven 0->1, the current sio value SHALL be shifted into the LSB of a 16-bit shift register.
REQ-018 A 5-bit bit counter SHALL count rising SCK edges 0..16; it is not reset between edges within a frame.
REQ-019 After the 16th low phase completes, the following SHALL all occur on the same cycle: cs=1, data_valid=1, temp_raw updated, temp_int updated, state=GAP.
REQ-020 cs low duration SHALL be exactly 33*CLK_DIV cycles; sck SHALL be 0 whenever cs=1.
REQ-021 GAP SHALL last CS_GAP cycles with busy=1; the machine then returns to IDLE with busy=0.
REQ-022 start SHALL be ignored outside IDLE; no queuing of requests.
REQ-023 start held high continuously SHALL produce back-to-back frames separated by CS_GAP+1 cycles of cs=1.
REQ-024 temp_raw and temp_int SHALL hold their values between frames and change only on a data_valid cycle.
REQ-025 temp_int SHALL be a pure sign-preserving bit slice; there is no rounding or saturation.

Reset
REQ-026 While rst=1, on the next clk edge: cs=1, sck=0, busy=0, data_valid=0, temp_raw=16'h0000, temp_int=9'h000, state=IDLE, and all counters and the shift register cleared.
REQ-027 rst asserted mid-frame SHALL abort the frame: cs rises immediately, no data_valid pulse, and outputs reset per REQ-026.
REQ-028 rst SHALL take priority over start on the same cycle.

Verification
REQ-029 Sensor model loaded with 16'h0B9F, CLK_DIV=4, single start pulse -> exactly 16 SCK rising edges, cs low for 132 cycles, one data_valid pulse, temp_raw=16'h0B9F, temp_int=23.
REQ-030 Sensor loaded with 16'hF380 -> temp_raw=16'hF380, temp_int=9'h1E7 (-25).
REQ-031 CLK_DIV=1, sensor loaded with 16'hA5A5 -> sck period 2 cycles, cs low 33 cycles, temp_raw=16'hA5A5.
REQ-032 start pulsed during SHIFT and during GAP -> ignored; exactly one frame and one data_valid pulse; busy falls CS_GAP cycles after data_valid.
REQ-033 rst asserted after the 7th SCK rising edge -> cs=1 and sck=0 next cycle, no data_valid, temp_raw=0; a following start yields a correct full frame.
REQ-034 start held high for 3 frames -> three data_valid pulses, with cs high for CS_GAP+1 cycles between frames and sck never toggling while cs=1.
